// File: rtl/icmp_server_hls_deadlock_mc_monitor.sv
// Deadlock monitor for an HLS dataflow region: qualifies stream/instance block flags over time.
// Optional DEADLOCK_MON_TIMESTAMP_EN adds a free-running cycle counter and first_block_time.
module icmp_server_hls_deadlock_mc_monitor #(
    parameter int NUM_AXIS       = 2,
    parameter int NUM_INST       = 1,
    parameter int PERSIST_CYCLES = 16,
    parameter int CNT_W          = 16,
    localparam int IDX_W = ($clog2(NUM_AXIS + 1) < 1) ? 1 : $clog2(NUM_AXIS + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                block_sticky,
    output logic [IDX_W-1:0]    block_chan,
    output logic [CNT_W-1:0]    block_cycles
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    ,
    output logic [31:0]         first_block_time
`endif
);

    typedef enum logic [1:0] {IDLE, SUSPECT, DEADLOCK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             block_q, block_d;
    logic             sticky_q, sticky_d;
    logic [IDX_W-1:0] chan_q, chan_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             inst_dl;
    logic             raw;
    logic             entry;
    logic [IDX_W-1:0] chan_sel;

    // An instance deadlock needs at least one active instance, with all active ones blocked.
    assign inst_dl = (|(~inst_idle_sigs)) & (&(inst_block_sigs | inst_idle_sigs));
    assign raw     = (|axis_block_sigs) | inst_dl;

    always_comb begin
        chan_sel = IDX_W'(NUM_AXIS);
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) chan_sel = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            IDLE: begin
                if (raw) begin
                    if (PERSIST_CYCLES == 1) begin
                        state_d = DEADLOCK;
                    end else begin
                        state_d = SUSPECT;
                        pcnt_d  = CNT_W'(1);
                    end
                end
            end
            SUSPECT: begin
                if (!raw) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else if (pcnt_q == CNT_W'(PERSIST_CYCLES - 1)) begin
                    state_d = DEADLOCK;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                end
            end
            DEADLOCK: begin
                if (!raw) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        entry    = (state_q != DEADLOCK) && (state_d == DEADLOCK);
        block_d  = (state_d == DEADLOCK);
        chan_d   = entry ? chan_sel : chan_q;
        cycles_d = cycles_q;
        if (entry) begin
            cycles_d = CNT_W'(1);
        end else if ((state_q == DEADLOCK) && (state_d == DEADLOCK) && (cycles_q != '1)) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
        // Entry wins over a coincident clear so a fresh deadlock is never lost.
        sticky_d = entry ? 1'b1 : (clear ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            block_q  <= 1'b0;
            sticky_q <= 1'b0;
            chan_q   <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            block_q  <= block_d;
            sticky_q <= sticky_d;
            chan_q   <= chan_d;
            cycles_q <= cycles_d;
        end
    end

    assign block        = block_q;
    assign block_sticky = sticky_q;
    assign block_chan   = chan_q;
    assign block_cycles = cycles_q;

`ifdef DEADLOCK_MON_TIMESTAMP_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ts_q, ts_d;

    always_comb begin
        cyc_d = cyc_q + 32'd1;
        ts_d  = ts_q;
        // Only the entry that raises the sticky flag records a timestamp.
        if (entry && !sticky_q) begin
            ts_d = cyc_q;
        end else if (clear) begin
            ts_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            ts_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            ts_q  <= ts_d;
        end
    end

    assign first_block_time = ts_q;
`endif

endmodule

// File: tb/tb_icmp_server_hls_deadlock_mc_monitor.sv
// Directed bench for the deadlock monitor: three parameterisations share one clock and reset.
module tb_icmp_server_hls_deadlock_mc_monitor;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    // DUT A: P=4, 2 streams, 1 instance
    logic [1:0]  a_axis = '0;
    logic [0:0]  a_idle = '1;
    logic [0:0]  a_iblk = '0;
    logic        a_clr  = 1'b0;
    logic        a_block, a_sticky;
    logic [1:0]  a_chan;
    logic [15:0] a_cyc;
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    logic [31:0] a_ts;
`endif

    icmp_server_hls_deadlock_mc_monitor #(
        .NUM_AXIS(2), .NUM_INST(1), .PERSIST_CYCLES(4), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset_n(reset_n),
        .axis_block_sigs(a_axis), .inst_idle_sigs(a_idle), .inst_block_sigs(a_iblk),
        .clear(a_clr), .block(a_block), .block_sticky(a_sticky),
        .block_chan(a_chan), .block_cycles(a_cyc)
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        , .first_block_time(a_ts)
`endif
    );

    // DUT B: P=1, 2 streams, 2 instances
    logic [1:0]  b_axis = '0;
    logic [1:0]  b_idle = '1;
    logic [1:0]  b_iblk = '0;
    logic        b_clr  = 1'b0;
    logic        b_block, b_sticky;
    logic [1:0]  b_chan;
    logic [15:0] b_cyc;
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    logic [31:0] b_ts;
`endif

    icmp_server_hls_deadlock_mc_monitor #(
        .NUM_AXIS(2), .NUM_INST(2), .PERSIST_CYCLES(1), .CNT_W(16)
    ) dut_b (
        .clock(clock), .reset_n(reset_n),
        .axis_block_sigs(b_axis), .inst_idle_sigs(b_idle), .inst_block_sigs(b_iblk),
        .clear(b_clr), .block(b_block), .block_sticky(b_sticky),
        .block_chan(b_chan), .block_cycles(b_cyc)
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        , .first_block_time(b_ts)
`endif
    );

    // DUT C: P=2, 4-bit counters
    logic [1:0]  c_axis = '0;
    logic [0:0]  c_idle = '1;
    logic [0:0]  c_iblk = '0;
    logic        c_clr  = 1'b0;
    logic        c_block, c_sticky;
    logic [1:0]  c_chan;
    logic [3:0]  c_cyc;
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    logic [31:0] c_ts;
`endif

    icmp_server_hls_deadlock_mc_monitor #(
        .NUM_AXIS(2), .NUM_INST(1), .PERSIST_CYCLES(2), .CNT_W(4)
    ) dut_c (
        .clock(clock), .reset_n(reset_n),
        .axis_block_sigs(c_axis), .inst_idle_sigs(c_idle), .inst_block_sigs(c_iblk),
        .clear(c_clr), .block(c_block), .block_sticky(c_sticky),
        .block_chan(c_chan), .block_cycles(c_cyc)
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        , .first_block_time(c_ts)
`endif
    );

    typedef struct {
        logic [1:0]  axis;
        logic [1:0]  idle;
        logic [1:0]  iblk;
        logic        clr;
        logic        blk;
        logic        stk;
        logic [1:0]  chan;
        logic [15:0] cyc;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edges++;
    endtask

    initial begin
        int ts_exp;
        ts_exp = 0;

        //            axis   idle   iblk  clr  blk  stk  chan   cyc
        vt[0]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};
        vt[1]  = '{2'b00, 2'b01, 2'b10, 1'b0, 1'b1, 1'b1, 2'd2, 16'd1};
        vt[2]  = '{2'b00, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1};
        vt[3]  = '{2'b10, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'd1, 16'd1};
        vt[4]  = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'd1, 16'd2};
        vt[5]  = '{2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'd1, 16'd2};
        vt[6]  = '{2'b00, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 2'd2, 16'd1};
        vt[7]  = '{2'b01, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 2'd2, 16'd2};
        vt[8]  = '{2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 2'd2, 16'd2};
        vt[9]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'd0, 16'd1};
        vt[10] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 16'd1};
        vt[11] = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 2'd0, 16'd1};
        vt[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 16'd1};

        #12;
        chk("rst_a_block", 32'(a_block), 0);
        chk("rst_a_sticky", 32'(a_sticky), 0);
        chk("rst_a_chan", 32'(a_chan), 0);
        chk("rst_a_cyc", 32'(a_cyc), 0);
        chk("rst_b_block", 32'(b_block), 0);
        chk("rst_c_cyc", 32'(c_cyc), 0);
        reset_n = 1'b1;

        // A: stream 1 blocked for 10 cycles
        a_axis = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("a1_block_k%0d", k), 32'(a_block), (k >= 4) ? 1 : 0);
            if (k == 4) begin
                chk("a1_chan", 32'(a_chan), 1);
                chk("a1_cyc_entry", 32'(a_cyc), 1);
                ts_exp = edges - 1;
            end
        end
        chk("a1_cyc_k10", 32'(a_cyc), 7);
        a_axis = 2'b00;
        tick();
        chk("a1_drop_block", 32'(a_block), 0);
        chk("a1_drop_cyc", 32'(a_cyc), 7);
        chk("a1_drop_chan", 32'(a_chan), 1);
        chk("a1_drop_sticky", 32'(a_sticky), 1);

        // A: 3-cycle burst, gap, 4-cycle burst
        a_axis = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("a2_burst1_k%0d", k), 32'(a_block), 0);
        end
        a_axis = 2'b00;
        tick();
        chk("a2_gap", 32'(a_block), 0);
        a_axis = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("a2_burst2_k%0d", k), 32'(a_block), (k == 4) ? 1 : 0);
        end
        chk("a2_chan", 32'(a_chan), 0);
        chk("a2_cyc", 32'(a_cyc), 1);
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        chk("a_ts_kept", a_ts, 32'(ts_exp));
`endif
        a_axis = 2'b00;
        a_clr  = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("a_clear_sticky", 32'(a_sticky), 0);
        chk("a_clear_chan_held", 32'(a_chan), 0);
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        chk("a_ts_cleared", a_ts, 0);
`endif

        // B: one-edge response, instance conditions, clear/entry collision
        for (int r = 0; r < 13; r++) begin
            b_axis = vt[r].axis;
            b_idle = vt[r].idle;
            b_iblk = vt[r].iblk;
            b_clr  = vt[r].clr;
            tick();
            chk($sformatf("b%0d_block", r), 32'(b_block), 32'(vt[r].blk));
            chk($sformatf("b%0d_sticky", r), 32'(b_sticky), 32'(vt[r].stk));
            chk($sformatf("b%0d_chan", r), 32'(b_chan), 32'(vt[r].chan));
            chk($sformatf("b%0d_cyc", r), 32'(b_cyc), 32'(vt[r].cyc));
        end
        b_clr = 1'b0;

        // C: saturation of a 4-bit dwell counter, then asynchronous reset mid-deadlock
        c_axis = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1)  chk("c_k1_block", 32'(c_block), 0);
            if (k == 2)  chk("c_k2_cyc", 32'(c_cyc), 1);
            if (k == 15) chk("c_k15_cyc", 32'(c_cyc), 14);
            if (k == 16) chk("c_k16_cyc", 32'(c_cyc), 15);
        end
        chk("c_k40_block", 32'(c_block), 1);
        chk("c_k40_cyc", 32'(c_cyc), 15);
        chk("c_k40_sticky", 32'(c_sticky), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("c_arst_block", 32'(c_block), 0);
        chk("c_arst_sticky", 32'(c_sticky), 0);
        chk("c_arst_chan", 32'(c_chan), 0);
        chk("c_arst_cyc", 32'(c_cyc), 0);
        chk("b_arst_sticky", 32'(b_sticky), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
